// File: rtl/mux4_rr_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_stream_arbiter_pkg
// Description : Shared constants, FSM state type and round-robin pick helper
//               for the 4-way stream arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux4_rr_stream_arbiter_pkg;

    localparam int NUM_REQ   = 4;
    localparam int REQ_IDX_W = 2;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Walks from the highest offset down so the lowest offset from ptr wins.
    function automatic logic [REQ_IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0]   valid,
        input logic [REQ_IDX_W-1:0] ptr
    );
        logic [REQ_IDX_W-1:0] pick;
        logic [REQ_IDX_W-1:0] idx;
        pick = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + REQ_IDX_W'(i);
            if (valid[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage : mux4_rr_stream_arbiter_pkg
`default_nettype wire

// File: rtl/mux4_rr_stream_arbiter_mux4_data_w.sv
`default_nettype none
// ============================================================================
// Module      : mux4_data_w
// Description : WIDTH-bit 4:1 data mux built from three 2:1 stages.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_data_w
    import mux4_rr_stream_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [NUM_REQ*WIDTH-1:0] in_data,
    input  logic [REQ_IDX_W-1:0]     sel,
    output logic [WIDTH-1:0]         out_data
);

    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;

    assign w_lo     = sel[0] ? in_data[1*WIDTH +: WIDTH] : in_data[0*WIDTH +: WIDTH];
    assign w_hi     = sel[0] ? in_data[3*WIDTH +: WIDTH] : in_data[2*WIDTH +: WIDTH];
    assign out_data = sel[1] ? w_hi : w_lo;

endmodule : mux4_data_w
`default_nettype wire

// File: rtl/mux4_rr_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_stream_arbiter
// Description : Round-robin 4:1 valid/ready stream arbiter with packet lock
//               and a registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_stream_arbiter
    import mux4_rr_stream_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       in_valid,
    input  logic [NUM_REQ-1:0]       in_last,
    input  logic [NUM_REQ*WIDTH-1:0] in_data,
    output logic [NUM_REQ-1:0]       in_ready,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [WIDTH-1:0]         out_data,
    output logic [REQ_IDX_W-1:0]     out_src,
    input  logic                     out_ready,
    output logic                     locked
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [REQ_IDX_W-1:0] r_ptr;
    logic [REQ_IDX_W-1:0] w_ptr_nxt;
    logic [REQ_IDX_W-1:0] r_lock_id;
    logic [REQ_IDX_W-1:0] w_lock_id_nxt;
    logic [REQ_IDX_W-1:0] w_win;
    logic [REQ_IDX_W-1:0] w_sel;
    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_can_load;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_mux_data;

    logic                 r_out_valid;
    logic                 r_out_last;
    logic [WIDTH-1:0]     r_out_data;
    logic [REQ_IDX_W-1:0] r_out_src;

    assign w_can_load = !r_out_valid || out_ready;
    assign w_win      = rr_pick(in_valid, r_ptr);
    assign w_sel      = (r_state == ST_LOCK) ? r_lock_id : w_win;

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_lock_id_nxt = r_lock_id;
        w_grant       = '0;
        case (r_state)
            ST_ARB: begin
                if (w_can_load && (|in_valid)) begin
                    w_grant[w_win] = 1'b1;
                    if (in_last[w_win]) begin
                        w_ptr_nxt = w_win + 1'b1;
                    end else begin
                        w_lock_id_nxt = w_win;
                        w_state_nxt   = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                // Other requesters are ignored until the open packet closes.
                if (w_can_load && in_valid[r_lock_id]) begin
                    w_grant[r_lock_id] = 1'b1;
                    if (in_last[r_lock_id]) begin
                        w_ptr_nxt   = r_lock_id + 1'b1;
                        w_state_nxt = ST_ARB;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    // No beat may be accepted while reset is asserted.
    assign in_ready = rst ? '0 : w_grant;
    assign w_accept = |in_ready;

    mux4_data_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in_data  (in_data),
        .sel      (w_sel),
        .out_data (w_mux_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_ARB;
            r_ptr     <= '0;
            r_lock_id <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_lock_id <= w_lock_id_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_last  <= in_last[w_sel];
            r_out_data  <= w_mux_data;
            r_out_src   <= w_sel;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign locked    = (r_state == ST_LOCK);

endmodule : mux4_rr_stream_arbiter
`default_nettype wire

// File: tb/tb_mux4_rr_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_stream_arbiter
// Description : Table-driven self-checking bench for the 4-way RR arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_stream_arbiter;

    localparam int WIDTH = 8;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic        out_last;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;
    logic        locked;

    int checks;
    int failures;

    mux4_rr_stream_arbiter #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_src;
        logic        exp_ol;
        logic        exp_lk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic o, input logic [3:0] er,
                       input logic eov, input logic [7:0] eod, input logic [1:0] es,
                       input logic eol, input logic elk);
        vec_t t;
        t.rst = r; t.valid = v; t.last = l; t.data = d; t.ordy = o;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_src = es;
        t.exp_ol = eol; t.exp_lk = elk;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic [31:0] d, input logic o);
        rst = r; in_valid = v; in_last = l; in_data = d; out_ready = o;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b1, 4'hF, 4'hF, 32'h13121110, 1'b1);

        // rst, valid, last, data, ordy | in_ready, ov, od, src, ol, locked
        add(1, 4'hF, 4'hF, 32'h13121110, 1, 4'b0000, 0, 8'h00, 2'd0, 0, 0);
        add(0, 4'hF, 4'hF, 32'h13121110, 1, 4'b0001, 0, 8'h00, 2'd0, 0, 0);
        add(0, 4'hF, 4'hF, 32'h13121110, 1, 4'b0010, 1, 8'h10, 2'd0, 1, 0);
        add(0, 4'hF, 4'hF, 32'h13121110, 1, 4'b0100, 1, 8'h11, 2'd1, 1, 0);
        add(0, 4'hF, 4'hF, 32'h13121110, 1, 4'b1000, 1, 8'h12, 2'd2, 1, 0);
        add(0, 4'hF, 4'hF, 32'h13121110, 1, 4'b0001, 1, 8'h13, 2'd3, 1, 0);
        add(0, 4'h0, 4'h0, 32'h00000000, 1, 4'b0000, 1, 8'h10, 2'd0, 1, 0);
        // req1 3-beat packet while req2 waits
        add(0, 4'h6, 4'h4, 32'h00B2A100, 1, 4'b0010, 0, 8'h10, 2'd0, 1, 0);
        add(0, 4'h6, 4'h4, 32'h00B2A200, 1, 4'b0010, 1, 8'hA1, 2'd1, 0, 1);
        add(0, 4'h6, 4'h6, 32'h00B2A300, 1, 4'b0010, 1, 8'hA2, 2'd1, 0, 1);
        add(0, 4'h6, 4'h4, 32'h00B2A400, 1, 4'b0100, 1, 8'hA3, 2'd1, 1, 0);
        // five cycles of backpressure with B2 held
        for (int i = 0; i < 5; i++)
            add(0, 4'h2, 4'h4, 32'h00B2A400, 0, 4'b0000, 1, 8'hB2, 2'd2, 1, 0);
        add(0, 4'h2, 4'h4, 32'h00B2A400, 1, 4'b0010, 1, 8'hB2, 2'd2, 1, 0);
        add(0, 4'hB, 4'hB, 32'hD300A5D0, 1, 4'b0010, 1, 8'hA4, 2'd1, 0, 1);
        // wrap between req3 and req0
        add(0, 4'h9, 4'h9, 32'hD30000D0, 1, 4'b1000, 1, 8'hA5, 2'd1, 1, 0);
        add(0, 4'h9, 4'h9, 32'hD30000D0, 1, 4'b0001, 1, 8'hD3, 2'd3, 1, 0);
        add(0, 4'h9, 4'h9, 32'hD30000D0, 1, 4'b1000, 1, 8'hD0, 2'd0, 1, 0);
        add(0, 4'h0, 4'h0, 32'h00000000, 1, 4'b0000, 1, 8'hD3, 2'd3, 1, 0);
        // reset in the middle of a req2 packet
        add(0, 4'h4, 4'h0, 32'h00C10000, 1, 4'b0100, 0, 8'hD3, 2'd3, 1, 0);
        add(0, 4'h4, 4'h0, 32'h00C20000, 1, 4'b0100, 1, 8'hC1, 2'd2, 0, 1);
        add(1, 4'h4, 4'h0, 32'h00C30000, 1, 4'b0000, 1, 8'hC2, 2'd2, 0, 1);
        add(0, 4'h5, 4'h1, 32'h00C300E0, 1, 4'b0001, 0, 8'h00, 2'd0, 0, 0);
        add(0, 4'h0, 4'h0, 32'h00000000, 1, 4'b0000, 1, 8'hE0, 2'd0, 1, 0);

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].ordy);
            @(negedge clk);
            chk("in_ready",  i, 32'(in_ready),  32'(vecs[i].exp_rdy));
            chk("out_valid", i, 32'(out_valid), 32'(vecs[i].exp_ov));
            chk("out_data",  i, 32'(out_data),  32'(vecs[i].exp_od));
            chk("out_src",   i, 32'(out_src),   32'(vecs[i].exp_src));
            chk("out_last",  i, 32'(out_last),  32'(vecs[i].exp_ol));
            chk("locked",    i, 32'(locked),    32'(vecs[i].exp_lk));
            @(posedge clk); #1;
        end

        // Hand sequence: ptr=1, load 55 from req1, then stall and check stability.
        drive(1'b0, 4'h2, 4'h2, 32'h00005500, 1'b1);
        begin : wait_load
            int n;
            n = 0;
            @(posedge clk); #1;
            drive(1'b0, 4'h1, 4'h1, 32'h00005577, 1'b0);
            while (!out_valid && n < 4) begin
                @(posedge clk); #1;
                n++;
            end
            chk("hs_load_valid", 100, 32'(out_valid), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hs_stall_data",  200 + i, 32'(out_data), 32'h55);
            chk("hs_stall_src",   200 + i, 32'(out_src),  32'd1);
            chk("hs_stall_ready", 200 + i, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_b2b_ready", 300, 32'(in_ready), 32'b0001);
        @(posedge clk); #1;
        in_valid = 4'h0;
        @(negedge clk);
        chk("hs_b2b_data",  301, 32'(out_data),  32'h77);
        chk("hs_b2b_src",   301, 32'(out_src),   32'd0);
        chk("hs_b2b_valid", 301, 32'(out_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux4_rr_stream_arbiter
`default_nettype wire
